// File: rtl/bounded_counter_if.sv
// Command, bound and status signals of one bounded_counter instance.
// The master drives commands and bounds; the slave (the counter) returns count and status.
interface bounded_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              up;
  logic              down;
  logic [STEP_W-1:0] step;
  logic              sat_mode;
  logic [WIDTH-1:0]  min_val;
  logic [WIDTH-1:0]  max_val;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic              at_max;
  logic              at_min;
  logic              wrap_pulse;
  logic              ovf_sticky;
  logic              unf_sticky;
  logic              cfg_err;

  modport master (
    output load, load_val, up, down, step, sat_mode, min_val, max_val, clr_flags,
    input  count, at_max, at_min, wrap_pulse, ovf_sticky, unf_sticky, cfg_err
  );

  modport slave (
    input  load, load_val, up, down, step, sat_mode, min_val, max_val, clr_flags,
    output count, at_max, at_min, wrap_pulse, ovf_sticky, unf_sticky, cfg_err
  );
endinterface

// File: rtl/bounded_counter.sv
// Up/down counter held inside a programmable [min_val, max_val] window, with
// wrap or saturate behaviour at the bounds and sticky crossing flags.
module bounded_counter #(
  parameter int               WIDTH   = 8,
  parameter int               STEP_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  bounded_counter_if.slave bus
);

  typedef logic [WIDTH:0] ext_t;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_DOWN, OP_UP} op_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, ovf_q, unf_q;
  logic             ovf_ev, unf_ev, wrap_d;
  logic             cfg_err, in_range;
  ext_t             step_x, sum, diff;
  op_e              op;

  assign cfg_err  = bus.min_val > bus.max_val;
  assign in_range = (count_q >= bus.min_val) && (count_q <= bus.max_val);

  // One extra bit keeps the carry of up and the borrow of down visible.
  assign step_x = ext_t'(bus.step);
  assign sum    = {1'b0, count_q} + step_x;
  assign diff   = {1'b0, count_q} - step_x;

  always_comb begin
    if (cfg_err)       op = OP_HOLD;
    else if (bus.load) op = OP_LOAD;
    else if (bus.down) op = OP_DOWN;
    else if (bus.up)   op = OP_UP;
    else               op = OP_HOLD;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
    count_d = count_q;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    unique case (op)
      OP_LOAD: begin
        if (bus.load_val < bus.min_val)      count_d = bus.min_val;
        else if (bus.load_val > bus.max_val) count_d = bus.max_val;
        else                                 count_d = bus.load_val;
      end
      OP_DOWN, OP_UP: begin
        if (!in_range) begin
          // Bounds moved under the count: snap to the closer side quietly.
          count_d = (count_q < bus.min_val) ? bus.min_val : bus.max_val;
        end else if (bus.step != '0) begin
          if (op == OP_DOWN) begin
            if (diff[WIDTH] || (diff[WIDTH-1:0] < bus.min_val)) begin
              unf_ev  = 1'b1;
              count_d = bus.sat_mode ? bus.min_val : bus.max_val;
            end else begin
              count_d = diff[WIDTH-1:0];
            end
          end else begin
            if (sum > {1'b0, bus.max_val}) begin
              ovf_ev  = 1'b1;
              count_d = bus.sat_mode ? bus.max_val : bus.min_val;
            end else begin
              count_d = sum[WIDTH-1:0];
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign wrap_d = (ovf_ev || unf_ev) && !bus.sat_mode;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      // A new crossing wins over a simultaneous clear.
      ovf_q   <= ovf_ev || (ovf_q && !bus.clr_flags);
      unf_q   <= unf_ev || (unf_q && !bus.clr_flags);
    end
  end

  assign bus.count      = count_q;
  assign bus.at_max     = (count_q == bus.max_val);
  assign bus.at_min     = (count_q == bus.min_val);
  assign bus.wrap_pulse = wrap_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.unf_sticky = unf_q;
  assign bus.cfg_err    = cfg_err;

endmodule
